// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package mips_fetch_pkg;

  localparam int unsigned PC_W      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // One prefetched instruction together with the PC of the word after it.
  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue for fetched instructions. A flush empties the queue and
// overrides any push or pop in the same cycle. Callers never push when full
// and never pop when empty.
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  fetch_entry_t     i_entry,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_count,
  output fetch_entry_t     o_head
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_d;

  // Entry storage; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_tail] <= i_entry;
    end
  end

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
  always_comb begin
    w_count_d = r_count;
    unique case ({i_push, i_pop})
      2'b10:   w_count_d = r_count + CNT_W'(1);
      2'b01:   w_count_d = r_count - CNT_W'(1);
      default: w_count_d = r_count;
    endcase
  end

  // Pointer and count state; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      if (i_pop)  r_head <= r_head + PTR_W'(1);
      r_count <= w_count_d;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues word addresses to a
// one-cycle-latency instruction memory and buffers returned words so decode
// stalls never drop or refetch. A redirect flushes everything in flight.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module if_fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [9:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed,
  output logic [31:0] perf_full
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]  r_fetch_pc;
  logic             r_inflight;
  logic [PC_W-1:0]  r_pc_inflight;

  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_entry;
  logic             w_push;
  logic             w_pop;
  logic             w_room;

  // A request is only issued when its response already has a reserved slot.
  always_comb begin
    w_room    = (32'(w_count) + 32'(r_inflight)) < DEPTH;
    imem_req  = rst && !redirect_valid && w_room;
    imem_addr = r_fetch_pc[11:2];
    w_push    = r_inflight && !redirect_valid;
    w_pop     = id_valid && !id_stall && !redirect_valid;
    w_entry   = '{instr: imem_rdata, pc_plus4: r_pc_inflight};
  end

  // Fetch PC and in-flight tracking; redirect wins over a new request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_pc_inflight <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc & ~32'h3;
      r_inflight <= 1'b0;
    end else if (imem_req) begin
      r_fetch_pc    <= r_fetch_pc + 32'd4;
      r_inflight    <= 1'b1;
      r_pc_inflight <= r_fetch_pc + 32'd4;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Decode-side view of the queue head; a nop with zero PC when empty.
  always_comb begin
    id_valid    = (w_count != '0);
    id_instr    = id_valid ? w_head.instr : NOP_INSTR;
    id_pc_plus4 = id_valid ? w_head.pc_plus4 : '0;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;
  logic [31:0] r_perf_full;

  // Free-running event counters; flushed counts queued plus discarded in-flight words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
      r_perf_full    <= '0;
    end else begin
      if (w_push) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (redirect_valid) begin
        r_perf_flushed <= r_perf_flushed + 32'(w_count) + 32'(r_inflight);
      end
      if (w_count == CNT_W'(DEPTH)) r_perf_full <= r_perf_full + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
  assign perf_full    = r_perf_full;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against a queue-level reference model.
// Perf counter checks are included when FETCH_PERF_CNT_EN is defined.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_stall = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
  logic [31:0] perf_full;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [31:0] m_q [$];
  logic [31:0] m_fetch_pc;
  bit          m_inflight;
  logic [31:0] m_inflight_pc;
  logic [31:0] m_fetched;
  logic [31:0] m_flushed;
  logic [31:0] m_full;

  logic [9:0]  r_addr_q = '0;

  always #5 clk = ~clk;

  // Instruction memory contents: a distinct pattern per word address.
  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {a, 12'hC3A, ~a};
  endfunction

  // Synchronous memory: data for the address seen at the previous edge.
  always @(posedge clk) r_addr_q <= imem_addr;
  assign imem_rdata = mem_word(r_addr_q);

  if_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed),
    .perf_full      (perf_full)
`endif
  );

`ifndef FETCH_PERF_CNT_EN
  assign perf_fetched = '0;
  assign perf_flushed = '0;
  assign perf_full    = '0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fetch_pc    = RESET_PC;
    m_inflight    = 1'b0;
    m_inflight_pc = '0;
    m_fetched     = '0;
    m_flushed     = '0;
    m_full        = '0;
  endtask

  task automatic check_perf();
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_flushed", perf_flushed, m_flushed);
    check("perf_full", perf_full, m_full);
`endif
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit stall);
    bit          exp_req;
    bit          exp_valid;
    logic [31:0] head_pc;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    id_stall       = stall;
    #1;
    exp_req   = !redir && ((m_q.size() + int'(m_inflight)) < int'(DEPTH));
    exp_valid = (m_q.size() != 0);
    head_pc   = exp_valid ? m_q[0] : 32'h0;
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, m_fetch_pc[11:2]);
    check("id_valid", id_valid, exp_valid);
    check("id_instr", id_instr, exp_valid ? mem_word(head_pc[11:2]) : 32'h0);
    check("id_pc_plus4", id_pc_plus4, exp_valid ? head_pc + 32'd4 : 32'h0);
    check_perf();
    if (m_q.size() == int'(DEPTH)) m_full++;
    if (redir) begin
      m_flushed  += m_q.size() + int'(m_inflight);
      m_q.delete();
      m_inflight = 1'b0;
      m_fetch_pc = {rpc[31:2], 2'b00};
    end else begin
      if (exp_valid && !stall) void'(m_q.pop_front());
      if (m_inflight) begin
        m_q.push_back(m_inflight_pc);
        m_fetched++;
      end
      if (exp_req) begin
        m_inflight    = 1'b1;
        m_inflight_pc = m_fetch_pc;
        m_fetch_pc    = m_fetch_pc + 32'd4;
      end else begin
        m_inflight = 1'b0;
      end
    end
    @(posedge clk);
  endtask

  task automatic random_phase(input int cycles, input int stall_pct, input int redir_pct);
    for (int i = 0; i < cycles; i++) begin
      step($urandom_range(99) < redir_pct, $urandom, $urandom_range(99) < stall_pct);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, imem_req, 32'h0);
    check({tag, "_valid"}, id_valid, 32'h0);
    check({tag, "_instr"}, id_instr, 32'h0);
    check({tag, "_pc4"}, id_pc_plus4, 32'h0);
    check_perf();
  endtask

  initial begin
    model_reset();
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    #1 rst = 1'b1;

    // Streaming with no stall from the first cycle out of reset.
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0);

    // Fill the queue under stall, then drain it.
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0);

    // Redirect with a request outstanding.
    step(1'b1, 32'h0000_0043, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0);

    // Redirect while stalled with a full queue.
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0200, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0);

    random_phase(300, 50, 5);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;

    random_phase(300, 20, 10);
    random_phase(200, 85, 2);
    random_phase(100, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
